if_stage: RTL and testbench

//  Instruction fetch stage of the MIPS core, directly upstream of decode/Control.

---
 rtl/if_stage.sv | 157 +++++++++++++++
 tb/tb_if_stage.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, single-outstanding SRAM-like fetch, one-entry decode buffer.
// Optional build macro: IF_PERF_CNT_EN adds perf_fetch_cnt / perf_stall_cnt outputs.
module if_stage #(
    parameter int unsigned            ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]      RESET_PC = ADDR_W'(32'hBFC0_0000)
) (
    input  logic              clk,
    input  logic              resetn,
    output logic              inst_sram_req,
    output logic [ADDR_W-1:0] inst_sram_addr,
    input  logic              inst_sram_addr_ok,
    input  logic              inst_sram_data_ok,
    input  logic [31:0]       inst_sram_rdata,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [31:0]       id_inst,
    output logic [ADDR_W-1:0] id_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    localparam int unsigned INST_W = 32;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   pc;
    logic [ADDR_W-1:0]   pc_nxt;
    logic                discard;
    logic                discard_nxt;
    logic                req_nxt;
    logic                id_valid_nxt;
    logic [INST_W-1:0]   id_inst_nxt;
    logic [ADDR_W-1:0]   id_pc_nxt;
    logic [ADDR_W-1:0]   target;

    // Redirect targets are word aligned; the low two bits are dropped.
    assign target = redirect_target & ~ADDR_W'(3);

    assign inst_sram_addr = pc;

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            BOOT: state_nxt = REQ;
            REQ: begin
                if (inst_sram_addr_ok) state_nxt = WAIT;
            end
            WAIT: begin
                if (inst_sram_data_ok) begin
                    state_nxt = (discard || redirect_valid) ? REQ : HOLD;
                end
            end
            HOLD: begin
                if (redirect_valid || id_ready) state_nxt = REQ;
            end
            default: state_nxt = BOOT;
        endcase
    end

    // Next values of the PC, discard flag and registered outputs.
    always_comb begin
        pc_nxt       = pc;
        discard_nxt  = discard;
        id_valid_nxt = id_valid;
        id_inst_nxt  = id_inst;
        id_pc_nxt    = id_pc;
        req_nxt      = (state_nxt == REQ);
        case (state)
            REQ: begin
                if (redirect_valid) begin
                    pc_nxt = target;
                    // Request already accepted for the old PC: its data must be dropped.
                    if (inst_sram_addr_ok) discard_nxt = 1'b1;
                end
            end
            WAIT: begin
                if (redirect_valid) pc_nxt = target;
                if (inst_sram_data_ok) begin
                    if (discard || redirect_valid) begin
                        discard_nxt = 1'b0;
                    end else begin
                        id_valid_nxt = 1'b1;
                        id_inst_nxt  = inst_sram_rdata;
                        id_pc_nxt    = pc;
                    end
                end else if (redirect_valid) begin
                    discard_nxt = 1'b1;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    id_valid_nxt = 1'b0;
                    pc_nxt       = target;
                end else if (id_ready) begin
                    id_valid_nxt = 1'b0;
                    pc_nxt       = pc + ADDR_W'(4);
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc            <= RESET_PC;
            discard       <= 1'b0;
            inst_sram_req <= 1'b0;
            id_valid      <= 1'b0;
            id_inst       <= '0;
            id_pc         <= '0;
        end else begin
            pc            <= pc_nxt;
            discard       <= discard_nxt;
            inst_sram_req <= req_nxt;
            id_valid      <= id_valid_nxt;
            id_inst       <= id_inst_nxt;
            id_pc         <= id_pc_nxt;
        end
    end

`ifdef IF_PERF_CNT_EN
    // Accepted-instruction and fetch-stall counters, free-running with wrap.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (id_valid && id_ready) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if ((state == REQ || state == WAIT) && !id_valid) perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage; inputs change and outputs are sampled 1ns after rising edges.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_sram_req;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        redirect_valid;
    logic [31:0] redirect_target;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    int errors = 0;
    int checks = 0;

    if_stage dut (
        .clk               (clk),
        .resetn            (resetn),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata),
        .id_valid          (id_valid),
        .id_ready          (id_ready),
        .id_inst           (id_inst),
        .id_pc             (id_pc),
        .redirect_valid    (redirect_valid),
        .redirect_target   (redirect_target)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch_cnt    (perf_fetch_cnt),
        .perf_stall_cnt    (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One fetch with single-cycle addr_ok/data_ok and immediate decode accept.
    task automatic fetch_one(input logic [31:0] addr, input logic [31:0] word, input logic [31:0] next_addr);
        check("req_up", 32'(inst_sram_req), 32'd1);
        check("req_addr", inst_sram_addr, addr);
        inst_sram_addr_ok = 1'b1;
        tick();
        inst_sram_addr_ok = 1'b0;
        check("wait_req", 32'(inst_sram_req), 32'd0);
        check("wait_valid", 32'(id_valid), 32'd0);
        inst_sram_data_ok = 1'b1;
        inst_sram_rdata   = word;
        tick();
        inst_sram_data_ok = 1'b0;
        check("hold_valid", 32'(id_valid), 32'd1);
        check("hold_inst", id_inst, word);
        check("hold_pc", id_pc, addr);
        check("hold_req", 32'(inst_sram_req), 32'd0);
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        check("acc_valid", 32'(id_valid), 32'd0);
        check("acc_req", 32'(inst_sram_req), 32'd1);
        check("acc_next", inst_sram_addr, next_addr);
    endtask

    initial begin
        resetn            = 1'b0;
        inst_sram_addr_ok = 1'b0;
        inst_sram_data_ok = 1'b0;
        inst_sram_rdata   = 32'h0;
        id_ready          = 1'b0;
        redirect_valid    = 1'b0;
        redirect_target   = 32'h0;

        // Reset state
        tick();
        tick();
        check("rst_req", 32'(inst_sram_req), 32'd0);
        check("rst_valid", 32'(id_valid), 32'd0);
        check("rst_inst", id_inst, 32'h0);
        check("rst_pc", id_pc, 32'h0);
        check("rst_addr", inst_sram_addr, 32'hBFC0_0000);
`ifdef IF_PERF_CNT_EN
        check("rst_fetch_cnt", perf_fetch_cnt, 32'h0);
        check("rst_stall_cnt", perf_stall_cnt, 32'h0);
`endif
        resetn = 1'b1;
        tick();

        // 1: back-to-back fetches
        fetch_one(32'hBFC0_0000, 32'h2408_0001, 32'hBFC0_0004);
        fetch_one(32'hBFC0_0004, 32'h2409_0002, 32'hBFC0_0008);
        fetch_one(32'hBFC0_0008, 32'h012A_4020, 32'hBFC0_000C);

        // 2: addr_ok delayed 4 cycles
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stall_req", 32'(inst_sram_req), 32'd1);
            check("stall_addr", inst_sram_addr, 32'hBFC0_000C);
        end
        fetch_one(32'hBFC0_000C, 32'h1000_FFFF, 32'hBFC0_0010);

        // 3: decode back-pressure in HOLD
        inst_sram_addr_ok = 1'b1;
        tick();
        inst_sram_addr_ok = 1'b0;
        inst_sram_data_ok = 1'b1;
        inst_sram_rdata   = 32'h8C43_0010;
        tick();
        inst_sram_data_ok = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("bp_valid", 32'(id_valid), 32'd1);
            check("bp_inst", id_inst, 32'h8C43_0010);
            check("bp_pc", id_pc, 32'hBFC0_0010);
            check("bp_req", 32'(inst_sram_req), 32'd0);
        end
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        check("bp_next", inst_sram_addr, 32'hBFC0_0014);

        // 4: redirect while waiting for data
        inst_sram_addr_ok = 1'b1;
        tick();
        inst_sram_addr_ok = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 32'h8000_1003;
        tick();
        redirect_valid = 1'b0;
        check("rw_valid", 32'(id_valid), 32'd0);
        inst_sram_data_ok = 1'b1;
        inst_sram_rdata   = 32'hDEAD_BEEF;
        tick();
        inst_sram_data_ok = 1'b0;
        check("rw_drop_valid", 32'(id_valid), 32'd0);
        check("rw_req", 32'(inst_sram_req), 32'd1);
        check("rw_addr", inst_sram_addr, 32'h8000_1000);
        fetch_one(32'h8000_1000, 32'h0800_0100, 32'h8000_1004);

        // 5: redirect and accept in the same HOLD cycle
        inst_sram_addr_ok = 1'b1;
        tick();
        inst_sram_addr_ok = 1'b0;
        inst_sram_data_ok = 1'b1;
        inst_sram_rdata   = 32'h03E0_0008;
        tick();
        inst_sram_data_ok = 1'b0;
        check("rh_valid", 32'(id_valid), 32'd1);
        check("rh_pc", id_pc, 32'h8000_1004);
        id_ready        = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h0040_0020;
        tick();
        id_ready       = 1'b0;
        redirect_valid = 1'b0;
        check("rh_valid_off", 32'(id_valid), 32'd0);
        check("rh_req", 32'(inst_sram_req), 32'd1);
        check("rh_addr", inst_sram_addr, 32'h0040_0020);
`ifdef IF_PERF_CNT_EN
        check("rh_fetch_cnt", perf_fetch_cnt, 32'd7);
`endif

        // Redirect in REQ without acceptance, then PC wrap
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFE;
        tick();
        redirect_valid = 1'b0;
        check("rq_req", 32'(inst_sram_req), 32'd1);
        check("rq_addr", inst_sram_addr, 32'hFFFF_FFFC);
        fetch_one(32'hFFFF_FFFC, 32'h1234_5678, 32'h0000_0000);

        // 6: reset during WAIT, then late data_ok
        inst_sram_addr_ok = 1'b1;
        tick();
        inst_sram_addr_ok = 1'b0;
        resetn = 1'b0;
        #1;
        check("mr_req", 32'(inst_sram_req), 32'd0);
        check("mr_addr", inst_sram_addr, 32'hBFC0_0000);
        check("mr_valid", 32'(id_valid), 32'd0);
`ifdef IF_PERF_CNT_EN
        check("mr_fetch_cnt", perf_fetch_cnt, 32'h0);
        check("mr_stall_cnt", perf_stall_cnt, 32'h0);
`endif
        tick();
        resetn            = 1'b1;
        inst_sram_data_ok = 1'b1;
        inst_sram_rdata   = 32'hBAD0_BAD0;
        tick();
        check("late_req", 32'(inst_sram_req), 32'd1);
        check("late_valid", 32'(id_valid), 32'd0);
        tick();
        inst_sram_data_ok = 1'b0;
        check("late_valid2", 32'(id_valid), 32'd0);
        check("late_addr", inst_sram_addr, 32'hBFC0_0000);
        fetch_one(32'hBFC0_0000, 32'h2408_0001, 32'hBFC0_0004);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
